key_entry_controller: RTL and testbench

- Sits directly downstream of the keypad scanner. Consumes its 4-bit row/column key code with a KeyRdy/KeyRd handshake.
- Decodes each key to a digit, operator or command and builds a 16-bit signed decimal operand.
- Hands {operand, opcode} to the calculator datapath over a valid/ready handshake.

---
 rtl/key_entry_controller.sv | 186 ++++++++++++++++++
 tb/tb_key_entry_controller.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_entry_controller.sv
// ---------------------------------------------------------------------------
// key_entry_controller
//
// Purpose:
//   Consumes key codes from the keypad scanner, builds a signed decimal
//   operand digit by digit and hands {operand, opcode} to the calculator
//   datapath.
//
// Ports:
//   Clock         in   system clock, rising edge
//   Reset         in   asynchronous, active-low reset
//   RowColVector  in   [3:0] scanner key code; key = {RowColVector[1:0], RowColVector[3:2]}
//   KeyRdy        in   scanner has a key (held until KeyRd is seen)
//   KeyRd         out  one-cycle acknowledge, the cycle after capture
//   Operand       out  [WIDTH-1:0] live entry value, two's complement
//   DigitCount    out  [2:0] digits entered in the current operand
//   OpValid       out  emitted operation pending
//   OpReady       in   datapath accepts the pending operation
//   OpOperand     out  [WIDTH-1:0] operand of the emitted operation
//   OpCode        out  [1:0] 00 add, 01 sub, 10 equals
//   EntryErr      out  one-cycle pulse when a digit is rejected
//
// Key map: 0-9 digit, A add, B sub, C sign toggle, D backspace, E equals,
//          F clear.
//
// Handshakes: a key is captured on a rising edge where the FSM is idle,
//   KeyRdy=1 and no operation is pending (OpValid=0). An emitted operation
//   holds OpValid/OpOperand/OpCode stable until an edge with OpReady=1.
//
// Build option: define KEY_BACKSPACE_EN to make key D a backspace
//   (magnitude/10). Without it, D is acknowledged and otherwise ignored.
// ---------------------------------------------------------------------------
module key_entry_controller #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [3:0]       RowColVector,
    input  logic             KeyRdy,
    output logic             KeyRd,
    output logic [WIDTH-1:0] Operand,
    output logic [2:0]       DigitCount,
    output logic             OpValid,
    input  logic             OpReady,
    output logic [WIDTH-1:0] OpOperand,
    output logic [1:0]       OpCode,
    output logic             EntryErr
);

    // Accumulator is 4 bits wider so magnitude*10+9 never wraps before the
    // range compare.
    localparam int            PW          = WIDTH + 4;
    localparam logic [PW-1:0] MAG_LIMIT   = PW'((2 ** (WIDTH - 1)) - 1);
    localparam logic [2:0]    DIGIT_LIMIT = 3'(MAX_DIGITS);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACK      = 2'd1,
        S_WAIT_LOW = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       key_idx;
    logic             capture;
    logic [WIDTH-1:0] magnitude;
    logic [WIDTH-1:0] mag_nxt;
    logic             sign;
    logic             sign_nxt;
    logic [2:0]       cnt_nxt;
    logic             err_nxt;
    logic             emit;
    logic [1:0]       code_nxt;
    logic [PW-1:0]    accum;
    logic [WIDTH-1:0] operand_nxt;

    assign key_idx = {RowColVector[1:0], RowColVector[3:2]};
    // A pending operation stalls the scanner; the release edge itself
    // cannot capture because OpValid is still 1 there.
    assign capture = (state == S_IDLE) && KeyRdy && !OpValid;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (capture) state_nxt = S_ACK;
            S_ACK:      state_nxt = S_WAIT_LOW;
            // Wait for the scanner to drop KeyRdy so one press is one capture.
            S_WAIT_LOW: if (!KeyRdy) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        KeyRd = (state == S_ACK);
    end

    // ---------------- Key decode / entry datapath ----------------
    always_comb begin
        mag_nxt  = magnitude;
        sign_nxt = sign;
        cnt_nxt  = DigitCount;
        err_nxt  = 1'b0;
        emit     = 1'b0;
        code_nxt = 2'b00;
        accum    = PW'(magnitude) * PW'(10) + PW'(key_idx);
        if (capture) begin
            case (key_idx)
                4'hA: begin emit = 1'b1; code_nxt = 2'b00; end
                4'hB: begin emit = 1'b1; code_nxt = 2'b01; end
                4'hE: begin emit = 1'b1; code_nxt = 2'b10; end
                4'hC: sign_nxt = ~sign;
                4'hD: begin
`ifdef KEY_BACKSPACE_EN
                    mag_nxt = magnitude / WIDTH'(10);
                    cnt_nxt = (DigitCount == 3'd0) ? 3'd0 : DigitCount - 3'd1;
                    if (mag_nxt == '0) sign_nxt = 1'b0;
`else
                    // Acknowledged only.
`endif
                end
                4'hF: begin
                    mag_nxt  = '0;
                    sign_nxt = 1'b0;
                    cnt_nxt  = 3'd0;
                end
                default: begin
                    // Digits 0-9.
                    if ((DigitCount == DIGIT_LIMIT) || (accum > MAG_LIMIT)) begin
                        err_nxt = 1'b1;
                    end else if ((magnitude != '0) || (key_idx != 4'd0)) begin
                        // A leading zero leaves both value and count alone.
                        mag_nxt = accum[WIDTH-1:0];
                        cnt_nxt = DigitCount + 3'd1;
                    end
                end
            endcase
            if (emit) begin
                mag_nxt  = '0;
                sign_nxt = 1'b0;
                cnt_nxt  = 3'd0;
            end
        end
        // Negating zero yields zero, so a toggled sign on 0 still shows 0.
        operand_nxt = sign_nxt ? (-mag_nxt) : mag_nxt;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            magnitude  <= '0;
            sign       <= 1'b0;
            DigitCount <= 3'd0;
            Operand    <= '0;
            EntryErr   <= 1'b0;
            OpValid    <= 1'b0;
            OpOperand  <= '0;
            OpCode     <= 2'b00;
        end else begin
            magnitude  <= mag_nxt;
            sign       <= sign_nxt;
            DigitCount <= cnt_nxt;
            Operand    <= operand_nxt;
            EntryErr   <= err_nxt;
            if (emit) begin
                // Operand still holds the value shown before this key.
                OpValid   <= 1'b1;
                OpOperand <= Operand;
                OpCode    <= code_nxt;
            end else if (OpValid && OpReady) begin
                OpValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_entry_controller.sv
// ---------------------------------------------------------------------------
// tb_key_entry_controller
//
// Directed key sequences followed by random key presses. A reference model
// (integer magnitude/sign/count, queue of expected operations) predicts the
// live operand, digit count, reject pulses and every emitted operation.
// Inputs are driven 2 ns after the falling edge; the operation monitor and
// pulse counters sample 3 ns after the falling edge.
// ---------------------------------------------------------------------------
module tb_key_entry_controller;

    localparam int W = 16;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [3:0]    RowColVector;
    logic          KeyRdy;
    logic          KeyRd;
    logic [W-1:0]  Operand;
    logic [2:0]    DigitCount;
    logic          OpValid;
    logic          OpReady;
    logic [W-1:0]  OpOperand;
    logic [1:0]    OpCode;
    logic          EntryErr;

    always #5 Clock = ~Clock;

    key_entry_controller #(.WIDTH(W), .MAX_DIGITS(5)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .RowColVector (RowColVector),
        .KeyRdy       (KeyRdy),
        .KeyRd        (KeyRd),
        .Operand      (Operand),
        .DigitCount   (DigitCount),
        .OpValid      (OpValid),
        .OpReady      (OpReady),
        .OpOperand    (OpOperand),
        .OpCode       (OpCode),
        .EntryErr     (EntryErr)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_mag  = 0;
    int          m_cnt  = 0;
    bit          m_sign = 1'b0;
    logic [17:0] exp_q[$];

    function automatic logic [W-1:0] m_operand();
        int v;
        v = m_sign ? -m_mag : m_mag;
        return W'(v);
    endfunction

    function automatic logic [3:0] enc(input int idx);
        logic [3:0] i;
        i = 4'(idx);
        return {i[1:0], i[3:2]};
    endfunction

    task automatic model_clear();
        m_mag  = 0;
        m_cnt  = 0;
        m_sign = 1'b0;
    endtask

    task automatic model_key(input int idx, output int err);
        int nv;
        err = 0;
        if (idx <= 9) begin
            nv = m_mag * 10 + idx;
            if (m_cnt == 5 || nv > 32767) err = 1;
            else if (!(m_mag == 0 && idx == 0)) begin
                m_mag = nv;
                m_cnt++;
            end
        end else begin
            case (idx)
                10: begin exp_q.push_back({m_operand(), 2'b00}); model_clear(); end
                11: begin exp_q.push_back({m_operand(), 2'b01}); model_clear(); end
                14: begin exp_q.push_back({m_operand(), 2'b10}); model_clear(); end
                12: m_sign = !m_sign;
                13: begin
`ifdef KEY_BACKSPACE_EN
                    m_mag = m_mag / 10;
                    if (m_cnt > 0) m_cnt--;
                    if (m_mag == 0) m_sign = 1'b0;
`endif
                end
                default: model_clear();
            endcase
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int kr_cnt  = 0;
    int err_cnt = 0;

    always @(negedge Clock) begin : monitor
        logic [17:0] e;
        #3;
        if (Reset) begin
            if (KeyRd) kr_cnt++;
            if (EntryErr) err_cnt++;
            if (OpValid && OpReady) begin
                check("op_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("op_operand", 32'(OpOperand), 32'(e[17:2]));
                    check("op_code", 32'(OpCode), 32'(e[1:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    bit rand_ready = 1'b0;

    task automatic tick();
        @(negedge Clock);
        #2;
        if (rand_ready) OpReady = 1'($urandom_range(0, 1));
    endtask

    task automatic press_key(input int idx, input int hold);
        int err_exp;
        int kr0;
        int er0;
        bit seen;
        seen = 1'b0;
        kr0 = kr_cnt;
        er0 = err_cnt;
        RowColVector = enc(idx);
        KeyRdy = 1'b1;
        for (int n = 0; n < 100 && !seen; n++) begin
            tick();
            if (KeyRd) seen = 1'b1;
        end
        check("keyrd_seen", 32'(seen), 32'd1);
        model_key(idx, err_exp);
        repeat (hold) tick();
        KeyRdy = 1'b0;
        repeat (3) tick();
        check("keyrd_pulses", 32'(kr_cnt - kr0), 32'd1);
        check("entry_err_pulses", 32'(err_cnt - er0), 32'(err_exp));
        check("operand", 32'(Operand), 32'(m_operand()));
        check("digit_count", 32'(DigitCount), 32'(m_cnt));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_keyrd"}, 32'(KeyRd), 32'd0);
        check({tag, "_operand"}, 32'(Operand), 32'd0);
        check({tag, "_digits"}, 32'(DigitCount), 32'd0);
        check({tag, "_opvalid"}, 32'(OpValid), 32'd0);
        check({tag, "_opoperand"}, 32'(OpOperand), 32'd0);
        check({tag, "_opcode"}, 32'(OpCode), 32'd0);
        check({tag, "_entryerr"}, 32'(EntryErr), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        bit seen;
        int idx;
        Reset = 1'b0;
        KeyRdy = 1'b0;
        RowColVector = 4'd0;
        OpReady = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        Reset = 1'b1;
        tick();

        // 1,2,3 then sign toggles
        press_key(1, 0); press_key(2, 0); press_key(3, 0);
        check("t123_operand", 32'(Operand), 32'h007B);
        check("t123_digits", 32'(DigitCount), 32'd3);
        press_key(12, 0);
        check("neg_operand", 32'(Operand), 32'hFF85);
        press_key(12, 0);
        check("pos_operand", 32'(Operand), 32'h007B);

        // add with stalled datapath and a second key waiting
        press_key(12, 0);
        press_key(10, 0);
        check("stall_opvalid", 32'(OpValid), 32'd1);
        RowColVector = enc(5);
        KeyRdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_keyrd", 32'(KeyRd), 32'd0);
            check("stall_hold", 32'(OpValid), 32'd1);
        end
        check("stall_opoperand", 32'(OpOperand), 32'hFF85);
        check("stall_opcode", 32'(OpCode), 32'd0);
        OpReady = 1'b1;
        tick();
        OpReady = 1'b0;
        check("release_opvalid", 32'(OpValid), 32'd0);
        check("release_no_capture", 32'(KeyRd), 32'd0);
        check("release_operand", 32'(Operand), 32'd0);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (KeyRd) seen = 1'b1;
        end
        check("after_release_keyrd", 32'(seen), 32'd1);
        begin
            int e;
            model_key(5, e);
        end
        KeyRdy = 1'b0;
        repeat (3) tick();
        check("after_release_operand", 32'(Operand), 32'h0005);

        // range limit and digit limit
        press_key(15, 0);
        press_key(3, 0); press_key(2, 0); press_key(7, 0); press_key(6, 0); press_key(8, 0);
        check("range_operand", 32'(Operand), 32'h0CCC);
        press_key(15, 0);
        press_key(3, 0); press_key(2, 0); press_key(7, 0); press_key(6, 0); press_key(7, 0);
        press_key(1, 0);
        check("max_operand", 32'(Operand), 32'h7FFF);
        check("max_digits", 32'(DigitCount), 32'd5);

        // equals accepted immediately
        OpReady = 1'b1;
        press_key(14, 0);
        check("equals_done", 32'(OpValid), 32'd0);
        OpReady = 1'b0;

        // long KeyRdy hold gives one capture
        press_key(15, 0);
        press_key(4, 6);
        press_key(5, 0);
        press_key(13, 0);
`ifdef KEY_BACKSPACE_EN
        check("backspace_operand", 32'(Operand), 32'd4);
        check("backspace_digits", 32'(DigitCount), 32'd1);
`else
        check("backspace_operand", 32'(Operand), 32'd45);
        check("backspace_digits", 32'(DigitCount), 32'd2);
`endif

        // leading zeros
        press_key(15, 0);
        press_key(0, 0); press_key(0, 0);
        check("lead_zero_digits", 32'(DigitCount), 32'd0);
        press_key(7, 0);
        check("lead_zero_seven", 32'(DigitCount), 32'd1);

        // reset while an operation is pending
        press_key(11, 0);
        check("pending_before_reset", 32'(OpValid), 32'd1);
        Reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_clear();
        exp_q.delete();
        repeat (2) tick();
        Reset = 1'b1;
        tick();
        press_key(15, 0);
        OpReady = 1'b1;
        press_key(14, 0);
        OpReady = 1'b0;
        check("post_reset_equals", 32'(OpValid), 32'd0);

        // random keys with random datapath back-pressure
        rand_ready = 1'b1;
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 9) < 7) idx = $urandom_range(0, 9);
            else idx = $urandom_range(10, 15);
            press_key(idx, $urandom_range(0, 2));
        end
        rand_ready = 1'b0;
        OpReady = 1'b1;
        repeat (5) tick();
        check("drain_opvalid", 32'(OpValid), 32'd0);
        check("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
